// File: rtl/reg_write_arb_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : reg_write_arb_if
// Description : Bundle of the arbiter's signals: the primary and secondary
//               write requests, the register-file write port, the pending
//               register checks and the FIFO occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_write_arb_if #(
    parameter int DEPTH = 4
) ();
    // Primary (pipeline) request
    logic        p_valid;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    // Secondary (long-latency) request
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_addr;
    logic [31:0] s_data;
    // Register-file write port
    logic        we;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    // Decode-stage pending checks
    logic [4:0]  chk1_addr;
    logic [4:0]  chk2_addr;
    logic        chk1_pend;
    logic        chk2_pend;
    // FIFO occupancy
    logic [$clog2(DEPTH):0] count;

    // Requester / decode side
    modport master (
        output p_valid, p_addr, p_data,
        output s_valid, s_addr, s_data,
        output chk1_addr, chk2_addr,
        input  s_ready, we, write_addr, write_data,
        input  chk1_pend, chk2_pend, count
    );

    // Arbiter side
    modport slave (
        input  p_valid, p_addr, p_data,
        input  s_valid, s_addr, s_data,
        input  chk1_addr, chk2_addr,
        output s_ready, we, write_addr, write_data,
        output chk1_pend, chk2_pend, count
    );
endinterface
`default_nettype wire

// File: rtl/reg_write_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : reg_write_arb
// Description : Merges pipeline results and queued long-latency results onto
//               the register file's single write port. The pipeline always
//               wins; a pipeline write kills older queued writes to the same
//               register so that stale data never lands on top of it.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arb #(
    parameter int DEPTH = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    reg_write_arb_if.slave bus
);
    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0] c_depth = DEPTH[c_aw:0];

    // Queue storage and per-entry live flags
    logic [4:0]  r_addr_q [DEPTH];
    logic [31:0] r_data_q [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [c_aw:0] r_wr_ptr;
    logic [c_aw:0] r_rd_ptr;

    // Output register
    logic        r_we;
    logic [4:0]  r_write_addr;
    logic [31:0] r_write_data;

    logic [c_aw:0]   w_count;
    logic            w_ready;
    logic            w_empty;
    logic [c_aw-1:0] w_head;
    logic [c_aw-1:0] w_tail;
    logic            w_head_live;
    logic            w_p_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_hit1;
    logic            w_hit2;

    // The wrap bit makes the pointer difference the true occupancy, 0..DEPTH
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_ready     = !rst && (w_count < c_depth);
    assign w_head      = r_rd_ptr[c_aw-1:0];
    assign w_tail      = r_wr_ptr[c_aw-1:0];
    assign w_head_live = !w_empty && r_live[w_head];

    // Writes to r0 are architecturally void, so they neither issue nor block
    assign w_p_issue = bus.p_valid && (bus.p_addr != 5'd0);

    // A secondary result is dropped if it targets r0 or if the pipeline is
    // writing the same register this cycle (the pipeline result is newer)
    assign w_push = bus.s_valid && w_ready && (bus.s_addr != 5'd0)
                    && !(w_p_issue && (bus.p_addr == bus.s_addr));

    // The head drains (live or killed) only in cycles the pipeline leaves free
    assign w_pop = !w_p_issue && !w_empty;

    // Pointer and live-flag bookkeeping, including the write-after-write kill
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_live   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_p_issue && r_live[i] && (r_addr_q[i] == bus.p_addr)) begin
                    r_live[i] <= 1'b0;
                end
            end
            if (w_pop) begin
                r_live[w_head] <= 1'b0;
                r_rd_ptr       <= r_rd_ptr + 1'b1;
            end
            // The tail slot is free whenever a push is allowed, so it never
            // collides with the head or with a kill of a live entry
            if (w_push) begin
                r_live[w_tail] <= 1'b1;
                r_wr_ptr       <= r_wr_ptr + 1'b1;
            end
        end
    end

    // Payload storage; meaningful only while the matching live flag is set
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_q[w_tail] <= bus.s_addr;
            r_data_q[w_tail] <= bus.s_data;
        end
    end

    // Output register, rewritten every cycle so a write never lingers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_write_addr <= 5'd0;
            r_write_data <= 32'd0;
        end else if (w_p_issue) begin
            r_we         <= 1'b1;
            r_write_addr <= bus.p_addr;
            r_write_data <= bus.p_data;
        end else if (w_pop && w_head_live) begin
            r_we         <= 1'b1;
            r_write_addr <= r_addr_q[w_head];
            r_write_data <= r_data_q[w_head];
        end else begin
            r_we         <= 1'b0;
            r_write_addr <= 5'd0;
            r_write_data <= 32'd0;
        end
    end

    // Pending lookup over the registered queue only
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i] && (r_addr_q[i] == bus.chk1_addr)) w_hit1 = 1'b1;
            if (r_live[i] && (r_addr_q[i] == bus.chk2_addr)) w_hit2 = 1'b1;
        end
    end

    assign bus.chk1_pend  = (bus.chk1_addr != 5'd0) && w_hit1;
    assign bus.chk2_pend  = (bus.chk2_addr != 5'd0) && w_hit2;
    assign bus.s_ready    = w_ready;
    assign bus.count      = w_count;
    assign bus.we         = r_we;
    assign bus.write_addr = r_write_addr;
    assign bus.write_data = r_write_data;
endmodule
`default_nettype wire

// File: tb/tb_reg_write_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_reg_write_arb
// Description : Self-checking bench for reg_write_arb. A queue-based model of
//               pending secondary writes predicts every output each cycle;
//               directed sequences are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arb;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_write_arb_if #(.DEPTH(DEPTH)) bus ();

    reg_write_arb #(.DEPTH(DEPTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          live;
    } ent_t;

    ent_t        q[$];
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
    int          total = 0;
    int          bad   = 0;

    // One comparison: counts it and reports a mismatch
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_pend(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].live && q[i].a == a) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: check registered outputs, apply inputs, check the
    // combinational outputs, then advance the model across the next edge
    task automatic step(input logic r, input logic pv, input logic [4:0] pa,
                        input logic [31:0] pd, input logic sv, input logic [4:0] sa,
                        input logic [31:0] sd, input logic [4:0] c1, input logic [4:0] c2);
        bit rdy;
        bit pi;
        ent_t h;
        @(negedge clk);
        check("we",         bus.we,         exp_we);
        check("write_addr", bus.write_addr, exp_wa);
        check("write_data", bus.write_data, exp_wd);
        check("count",      bus.count,      q.size());
        rst           = r;
        bus.p_valid   = pv;
        bus.p_addr    = pa;
        bus.p_data    = pd;
        bus.s_valid   = sv;
        bus.s_addr    = sa;
        bus.s_data    = sd;
        bus.chk1_addr = c1;
        bus.chk2_addr = c2;
        #1;
        rdy = !r && (q.size() < DEPTH);
        check("s_ready",   bus.s_ready,   rdy);
        check("chk1_pend", bus.chk1_pend, model_pend(c1));
        check("chk2_pend", bus.chk2_pend, model_pend(c2));
        if (r) begin
            q.delete();
            exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
        end else begin
            pi = pv && (pa != 5'd0);
            exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
            if (pi) begin
                exp_we = 1'b1; exp_wa = pa; exp_wd = pd;
                foreach (q[i]) if (q[i].a == pa) q[i].live = 1'b0;
            end else if (q.size() > 0) begin
                h = q.pop_front();
                if (h.live) begin
                    exp_we = 1'b1; exp_wa = h.a; exp_wd = h.d;
                end
            end
            if (sv && rdy && sa != 5'd0 && !(pi && pa == sa))
                q.push_back('{a: sa, d: sd, live: 1'b1});
        end
    endtask

    task automatic idle(input int n, input logic [4:0] c1, input logic [4:0] c2);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, c1, c2);
    endtask

    initial begin
        bus.p_valid = 0; bus.p_addr = 0; bus.p_data = 0;
        bus.s_valid = 0; bus.s_addr = 0; bus.s_data = 0;
        bus.chk1_addr = 0; bus.chk2_addr = 0;
        exp_we = 0; exp_wa = 0; exp_wd = 0;
        repeat (3) @(posedge clk);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Primary write, one-cycle latency
        step(0, 1, 5, 32'h0000_1234, 0, 0, 0, 0, 0);
        idle(2, 0, 0);

        // Secondary write into an empty queue
        step(0, 0, 0, 0, 1, 7, 32'hAAAA_0000, 7, 0);
        idle(4, 7, 0);

        // Busy primary fills the queue, fifth request held until space
        for (int i = 0; i < 6; i++)
            step(0, 1, 5'(i + 1), 32'h100 + i, i < 5, 5'(8 + i), 32'h200 + i, 10, 12);
        for (int i = 0; i < 8; i++)
            step(0, 0, 0, 0, i < 2, 12, 32'h20C, 10, 12);

        // WAW kill of a queued r9
        step(0, 1, 1, 32'h11, 1, 9, 32'h1, 9, 0);
        step(0, 1, 2, 32'h22, 0, 0, 0, 9, 0);
        step(0, 1, 9, 32'h2, 0, 0, 0, 9, 9);
        idle(4, 9, 9);

        // r0 on both sources
        step(0, 1, 0, 32'hDEAD, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 32'hBEEF, 0, 0);
        idle(3, 0, 0);

        // Reset while three live entries are queued
        for (int i = 0; i < 3; i++)
            step(0, 1, 5'(20 + i), 32'h300 + i, 1, 5'(3 + i), 32'h400 + i, 3, 5);
        step(0, 0, 0, 0, 0, 0, 0, 3, 5);
        step(1, 0, 0, 0, 0, 0, 0, 3, 5);
        idle(5, 4, 5);

        // Randomized traffic over a small register range to force collisions
        for (int i = 0; i < 3000; i++) begin
            int mode;
            int ppct;
            logic r;
            mode = (i / 300) % 3;
            ppct = (mode == 0) ? 30 : (mode == 1) ? 90 : 5;
            r = ($urandom_range(0, 199) == 0);
            step(r,
                 $urandom_range(0, 99) < ppct, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 99) < 60,   5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        end
        idle(8, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/reg_write_arb.md
# reg_write_arb

Write-side arbiter for the 32-entry general-purpose register file. It merges register results from two sources onto the file's single write port (`we`, `write_addr`, `write_data`). The in-order pipeline result path always has priority. Results from a long-latency unit (divider or load-miss path) wait in a small FIFO. The block also reports whether a register still has a queued write, so the decode stage can stall.

## Interface
Parameters:
- `DEPTH`, default 4: secondary FIFO entries. Must be a power of 2, ≥2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `p_valid`  in  1  primary (pipeline) write request. There is no ready signal; it is always accepted.
- `p_addr`  in  5  primary destination register.
- `p_data`  in  32  primary write data.
- `s_valid`  in  1  secondary write request.
- `s_ready`  out  1  secondary may be accepted; transfer occurs when `s_valid && s_ready`.
- `s_addr`  in  5  secondary destination register.
- `s_data`  in  32  secondary write data.
- `we`  out  1  register-file write enable (registered).
- `write_addr`  out  5  register-file write address (registered).
- `write_data`  out  32  register-file write data (registered).
- `chk1_addr`, `chk2_addr`  in  5 each  decode-stage source registers.
- `chk1_pend`, `chk2_pend`  out  1 each  a live queued write targets that register.
- `count`  out  clog2(DEPTH)+1  FIFO occupancy, including killed entries.

## Operation
- **FIFO.** Circular buffer with read/write pointers, one wrap bit, and a per-entry live flag.
- **`s_ready`.** `s_ready = !rst && (count < DEPTH)`, driven from registered state only. When the FIFO is full, `s_ready` is 0 even if a pop happens in the same cycle.
- **Accepting a secondary request:**
  - Request with `s_addr==0`: accepted and discarded; `count` does not change.
  - Request arriving in the same cycle as a primary write to the same non-zero address (`p_valid` set): accepted and discarded. The primary result is newer and wins.
  - Otherwise: pushed as a live entry.
- **Issue priority, evaluated each cycle:**
  1. `p_valid && p_addr!=0`: issue the primary write.
  2. Else, if the FIFO head is live: issue the head and pop it.
  3. Else, if the FIFO head is killed: pop it with no write issued.
  4. Else: issue nothing (`we` goes to 0).
- **Primary with `p_addr==0`.** Ignored; it does not block rule 2 or rule 3.
- **WAW kill.** A primary issue to address X clears the live flag of every FIFO entry whose address is X, in the same edge. Killed entries are still counted until popped.
- **Pop rate.** At most one pop per cycle (live or killed). Push and pop in the same cycle are allowed when not full, giving a net count change of 0.
- **Ordering.** Live FIFO entries drain in acceptance order.
- **Pending check.** `chkN_pend = (chkN_addr != 0) && (some live FIFO entry has address chkN_addr)`.
  - Combinational over registered FIFO state.
  - A secondary request accepted in the current cycle is not included.
  - The write already in the output register is not included; the register file forwards it.

## Timing
- **Reset values:** `we=0`, `write_addr=0`, `write_data=0`, `count=0`, `s_ready=0` while `rst` is high, `chk*_pend=0`. Pointers and all live flags are cleared.
- **Reset mid-operation:** the next edge flushes every queued entry; no further writes from those entries occur.
- **Primary latency:** request in cycle N, `we`/`write_addr`/`write_data` valid in cycle N+1.
- **Secondary latency:** accepted in cycle N into an empty FIFO with no primary traffic; the entry becomes head in N+1 and `we` is asserted in N+2.
- **Primary starvation of the FIFO:** a primary write every cycle starves the FIFO indefinitely. This is by design; the pipeline guarantees gaps.
- **Output register:** the output register is rewritten every cycle; `we` is never held over from a previous cycle.
- **Pointer wrap:** pointers wrap modulo DEPTH; full versus empty is distinguished by the wrap bit.

## Test plan
- Reset, then `p_valid=1`, `p_addr=5`, `p_data=0x00001234` for one cycle → next cycle `we=1`, `write_addr=5`, `write_data=0x00001234`; the cycle after, `we=0`.
- Secondary push `s_addr=7`, `s_data=0xAAAA0000` with primary idle:
  - `count=1` and `chk1_pend=1` (with `chk1_addr=7`) one cycle after acceptance.
  - `we=1`, `write_addr=7` two cycles after acceptance.
  - `chk1_pend=0` and `count=0` afterwards.
- Primary busy every cycle to r1..r6; push 4 secondary requests (r8..r11):
  - `count=4`, `s_ready=0`; a 5th request (r12) is held.
  - Primary stops → writes r8, r9, r10, r11, r12 on consecutive cycles.
  - `s_ready` returns to 1 the cycle after the first pop.
- WAW kill: secondary r9=0x1 queued behind a busy primary; then primary r9=0x2:
  - Exactly one write to r9 is observed, with data 0x2.
  - `chk*_pend` for r9 drops to 0 the cycle after the primary issue.
  - The killed entry pops with no `we`.
- r0 handling:
  - Primary `p_addr=0` → `we=0`.
  - Secondary `s_addr=0` → `s_ready=1`, `count` unchanged, no write ever issued.
- Reset mid-drain with 3 live entries → cycle after the reset edge: `we=0`, `count=0`, `chk*_pend=0`; no queued data is written after reset deasserts.
